// File: rtl/gate_bist_ctrl.sv
// Exhaustive self-test sequencer for one combinational gate: walks every input
// vector, waits for the gate to settle, and checks it against a golden truth table.
module gate_bist_ctrl #(
  parameter int N_IN = 3,
  parameter int SETTLE = 2,
  parameter logic [(2**N_IN)-1:0] TRUTH = 8'h15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid,
  output logic [1:0]      state_dbg
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE     = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          mismatch;

  assign mismatch  = (dut_out != TRUTH[dut_in]);
  assign pass      = done && (fail_count == '0);
  assign state_dbg = state;

  // Handshake: start is a level sampled only in IDLE/DONE; abort is a level
  // honoured only while busy and wins over the CHECK-cycle transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      fail_count       <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= SETTLE_ST;
            settle_cnt       <= '0;
            dut_in           <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        SETTLE_ST: begin
          if (abort) begin
            state  <= IDLE;
            dut_in <= '0;
            busy   <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (abort) begin
            state  <= IDLE;
            dut_in <= '0;
            busy   <= 1'b0;
          end else begin
            if (mismatch) begin
              fail_count <= fail_count + CNT_ONE;
              if (!first_fail_valid) begin
                first_fail_vec   <= dut_in;
                first_fail_valid <= 1'b1;
              end
            end
            // The final vector stays on dut_in so the gate is left in a known state.
            if (dut_in == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= SETTLE_ST;
              settle_cnt <= '0;
              dut_in     <= dut_in + VEC_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: a run-level reference model checked every cycle,
// plus literal expectations for the aoi, stuck-at, abort, reset and xnor cases.
module tb_gate_bist_ctrl;

  localparam int N = 3;
  localparam int S = 2;
  localparam logic [7:0] TRUTH_TB = 8'h15;
  localparam int NVEC = 8;
  localparam int RUN_LEN = NVEC * (S + 1);

  logic       clk;
  logic       rst_n;
  logic       start, abort;
  logic       dut_out;
  logic [2:0] dut_in;
  logic       busy, done, pass;
  logic [3:0] fail_count;
  logic [2:0] first_fail_vec;
  logic       first_fail_valid;
  logic [1:0] state_dbg;

  logic       start2;
  logic       dut_out2;
  logic [1:0] dut_in2;
  logic       busy2, done2, pass2;
  logic [2:0] fail_count2;
  logic [1:0] first_fail_vec2;
  logic       first_fail_valid2;
  logic [1:0] state_dbg2;

  int errors = 0;
  int checks = 0;

  // Gate-under-test behaviour: 0 = correct aoi, 1 = stuck-at-1, 2 = aoi with flipped entries
  int         fault_mode = 0;
  logic [7:0] flip_mask  = '0;

  gate_bist_ctrl #(.N_IN(N), .SETTLE(S), .TRUTH(TRUTH_TB)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid),
    .state_dbg(state_dbg)
  );

  gate_bist_ctrl #(.N_IN(2), .SETTLE(1), .TRUTH(4'b0110)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .dut_out(dut_out2),
    .dut_in(dut_in2), .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail_count2),
    .first_fail_vec(first_fail_vec2), .first_fail_valid(first_fail_valid2),
    .state_dbg(state_dbg2)
  );

  function automatic logic gate_out(input logic [2:0] v);
    logic aoi;
    aoi = ~((v[2] & v[1]) | v[0]);
    case (fault_mode)
      1:       return 1'b1;
      2:       return aoi ^ flip_mask[v];
      default: return aoi;
    endcase
  endfunction

  always_comb dut_out  = gate_out(dut_in);
  always_comb dut_out2 = ~(dut_in2[1] ^ dut_in2[0]);

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A run is "k edges since the accepting start edge"; vector v occupies
  // k in [v*(S+1), v*(S+1)+S] and is judged on the edge that ends that span.
  logic       m_busy, m_done, m_ffvalid;
  int         m_k, m_fail;
  logic [2:0] m_din, m_ffv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_ffvalid = 0; m_k = 0; m_fail = 0; m_din = 0; m_ffv = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0; m_ffvalid = 0; m_k = 0; m_fail = 0; m_din = 0; m_ffv = 0;
      end
    end else if (abort) begin
      m_busy = 0; m_din = 0;
    end else begin
      m_k++;
      if (m_k % (S + 1) == 0) begin
        int v;
        v = m_k / (S + 1) - 1;
        if (gate_out(3'(v)) != TRUTH_TB[v]) begin
          m_fail++;
          if (!m_ffvalid) begin m_ffvalid = 1; m_ffv = 3'(v); end
        end
      end
      if (m_k == RUN_LEN) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_din = 3'(m_k / (S + 1));
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("dut_in", dut_in, m_din);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("pass", pass, m_done && m_fail == 0);
    chk("fail_count", fail_count, m_fail);
    chk("first_fail_valid", first_fail_valid, m_ffvalid);
    chk("first_fail_vec", first_fail_vec, m_ffv);
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Edges from the start edge until done rises, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int edges;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dut_in", dut_in, 0);
    chk("reset_fail_count", fail_count, 0);
    rst_n = 1'b1;

    // Clean aoi run; start pulses while busy must not disturb the timing.
    fault_mode = 0;
    pulse_start();
    fork
      wait_done(edges);
      begin
        repeat (7) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
      end
    join
    chk("clean_latency", edges, 24);
    chk("clean_pass", pass, 1);
    chk("clean_ffvalid", first_fail_valid, 0);

    // Stuck-at-1 output, started from DONE.
    fault_mode = 1;
    pulse_start();
    chk("restart_done_drop", done, 0);
    wait_done(edges);
    chk("stuck_latency", edges, 24);
    chk("stuck_fail_count", fail_count, 5);
    chk("stuck_first_vec", first_fail_vec, 1);
    chk("stuck_pass", pass, 0);

    // Abort on the CHECK cycle of vector 4.
    pulse_start();
    repeat (14) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_fail_count", fail_count, 2);
    chk("abort_dut_in", dut_in, 0);
    fault_mode = 0;
    pulse_start();
    chk("post_abort_cleared", fail_count, 0);
    wait_done(edges);
    chk("post_abort_latency", edges, 24);
    chk("post_abort_pass", pass, 1);

    // Asynchronous reset at vector 5, between clock edges.
    fault_mode = 1;
    pulse_start();
    repeat (16) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_dut_in", dut_in, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_fail_count", fail_count, 0);
    chk("async_rst_ffvalid", first_fail_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    fault_mode = 0;
    pulse_start();
    wait_done(edges);
    chk("post_rst_latency", edges, 24);
    chk("post_rst_pass", pass, 1);

    // Second configuration: xor table against an xnor gate.
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    edges = 0;
    while (!done2 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("xnor_latency", edges, 8);
    chk("xnor_fail_count", fail_count2, 4);
    chk("xnor_first_vec", first_fail_vec2, 0);
    chk("xnor_ffvalid", first_fail_valid2, 1);
    chk("xnor_pass", pass2, 0);

    // Randomised runs: random faults, stray starts, occasional aborts.
    for (int r = 0; r < 12; r++) begin
      int cyc;
      bit abort_en;
      fault_mode = $urandom_range(0, 2);
      flip_mask  = 8'($urandom);
      abort_en   = ($urandom_range(0, 2) == 0);
      pulse_start();
      cyc = 0;
      while (m_busy && cyc < 200) begin
        @(posedge clk); #1;
        start = ($urandom_range(0, 3) == 0);
        abort = abort_en && ($urandom_range(0, 29) == 0);
        cyc++;
      end
      chk("random_run_bounded", int'(cyc < 200), 1);
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      repeat (2) @(posedge clk);
    end

    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
